// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX byte stream between N_REQ requesters.
// A grant is held from the first byte of a packet until the byte flagged req_last is accepted.
// An optional channel-ID header byte (HDR_BASE + grant index) precedes each packet. A stall
// watchdog releases the grant if the granted requester stops presenting data mid-packet.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester byte valid
//   req_data     per-requester byte, requester i on bits [8i+7:8i]
//   req_last     last byte of a packet (qualified by req_valid)
//   req_ready    per-requester accept (only the granted requester, in DATA, slot free)
//   tx_data      byte presented to the TX FIFO
//   tx_valid     tx_data valid
//   tx_ready     downstream accept
//   grant_id     current / most recent granted requester
//   busy         high while a packet (header or data) is in progress
//   timeout_err  one-cycle pulse when the watchdog aborts a packet
module uart_tx_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter bit          HDR_EN   = 1'b1,
  parameter logic [7:0]  HDR_BASE = 8'hA0,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned IDW      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               timeout_err
);

  // The counter runs 0..TIMEOUT-1; the abort fires on the cycle it would reach TIMEOUT.
  localparam int unsigned CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLim = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e          state_q;
  logic [IDW-1:0]  grant_q;
  logic [IDW-1:0]  last_grant_q;
  logic [7:0]      tx_data_q;
  logic            tx_valid_q;
  logic [CntW-1:0] stall_cnt_q;
  logic            timeout_q;

  logic            slot_free;
  logic            gnt_valid;
  logic            gnt_last;
  logic [7:0]      gnt_data;
  logic            xfer;
  logic            found;
  logic [IDW-1:0]  next_grant;
  logic [IDW-1:0]  scan_idx;

  assign slot_free = !tx_valid_q || tx_ready;
  assign gnt_valid = req_valid[grant_q];
  assign gnt_last  = req_last[grant_q];
  assign gnt_data  = req_data[{grant_q, 3'b000} +: 8];
  assign xfer      = (state_q == StData) && slot_free && gnt_valid;

  always_comb begin
    req_ready = '0;
    if (state_q == StData && slot_free) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  // Round-robin: first valid requester scanning upward from the one after last_grant.
  always_comb begin
    found      = 1'b0;
    next_grant = last_grant_q;
    scan_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      scan_idx = IDW'((32'(last_grant_q) + k) % N_REQ);
      if (!found && req_valid[scan_idx]) begin
        found      = 1'b1;
        next_grant = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= IDW'(N_REQ - 1);
      last_grant_q <= IDW'(N_REQ - 1);
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      stall_cnt_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      // Drain the slot on handshake; a load below overrides this.
      if (tx_valid_q && tx_ready) begin
        tx_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (found) begin
            grant_q     <= next_grant;
            stall_cnt_q <= '0;
            state_q     <= HDR_EN ? StHdr : StData;
          end
        end
        StHdr: begin
          if (slot_free) begin
            tx_data_q  <= HDR_BASE + 8'(grant_q);
            tx_valid_q <= 1'b1;
            state_q    <= StData;
          end
        end
        StData: begin
          if (xfer) begin
            tx_data_q   <= gnt_data;
            tx_valid_q  <= 1'b1;
            stall_cnt_q <= '0;
            if (gnt_last) begin
              last_grant_q <= grant_q;
              state_q      <= StIdle;
            end
          end else if (TIMEOUT > 0 && !gnt_valid) begin
            // Only requester inactivity counts; backpressure with valid high does not.
            if (stall_cnt_q == CntLim) begin
              timeout_q    <= 1'b1;
              last_grant_q <= grant_q;
              stall_cnt_q  <= '0;
              state_q      <= StIdle;
            end else begin
              stall_cnt_q <= stall_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_q;

endmodule
